// File: rtl/conv_mac_sequencer_if.sv
// Bus between the convolution controller, the shared sample/coefficient buffer
// read port and the MAC sequencer.
interface conv_mac_sequencer_if #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16
);
  logic                      start_conv;
  logic signed [DATA_W-1:0]  sample_data;
  logic signed [COEFF_W-1:0] coeff_data;
  logic                      rd_en;
  logic [ADDR_W-1:0]         tap_addr;
  logic                      busy;
  logic                      conv_complete;
  logic signed [DATA_W-1:0]  conv_result;
  logic                      overflow;

  modport master (
    output start_conv, sample_data, coeff_data,
    input  rd_en, tap_addr, busy, conv_complete, conv_result, overflow
  );

  modport slave (
    input  start_conv, sample_data, coeff_data,
    output rd_en, tap_addr, busy, conv_complete, conv_result, overflow
  );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Walks the taps of one convolution output over the shared buffer read port,
// multiply-accumulates through a 2-stage pipeline and returns a saturated result.
module conv_mac_sequencer #(
  parameter int NUM_TAPS  = 8,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 16,
  parameter int COEFF_W   = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic                clk,
  input  logic                n_rst,
  conv_mac_sequencer_if.slave bus
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = PROD_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, READ, DRAIN, DONE, REARM} state_t;

  // Returns {overflow, result}: scale the sum down, then clamp to DATA_W signed.
  function automatic logic [DATA_W:0] sat_shift(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] sh;
    sh = sum >>> FRAC_BITS;
    if (sh > SAT_MAX)
      sat_shift = {1'b1, SAT_MAX[DATA_W-1:0]};
    else if (sh < SAT_MIN)
      sat_shift = {1'b1, SAT_MIN[DATA_W-1:0]};
    else
      sat_shift = {1'b0, sh[DATA_W-1:0]};
  endfunction

  state_t                   state;
  logic [ADDR_W-1:0]        tap_cnt;
  logic                     drain_cnt;
  logic                     rd_en_r;
  logic                     busy_r;
  logic                     complete_r;
  logic                     ovf_r;
  logic signed [DATA_W-1:0] result_r;

  logic                     vld_p0;
  logic signed [DATA_W-1:0] smp_p0;
  logic signed [COEFF_W-1:0] cof_p0;
  logic                     vld_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]  acc_p2;

  logic                     start_acc;
  logic                     abort;
  logic                     pipe_clr;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  final_sum;
  logic [DATA_W:0]          sat_res;

  assign start_acc = (state == IDLE) && bus.start_conv;
  assign abort     = ((state == READ) || (state == DRAIN)) && !bus.start_conv;
  assign pipe_clr  = start_acc || abort;

  assign smp_p0 = bus.sample_data;
  assign cof_p0 = bus.coeff_data;

  // The last product lands on the same edge that enters DONE, so fold it in here.
  assign prod_ext  = {{ADDR_W{prod_p1[PROD_W-1]}}, prod_p1};
  assign final_sum = vld_p1 ? (acc_p2 + prod_ext) : acc_p2;
  assign sat_res   = sat_shift(final_sum);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      tap_cnt    <= '0;
      drain_cnt  <= 1'b0;
      rd_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      complete_r <= 1'b0;
      ovf_r      <= 1'b0;
      result_r   <= '0;
    end else begin
      complete_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_conv) begin
            state   <= READ;
            rd_en_r <= 1'b1;
            tap_cnt <= '0;
            busy_r  <= 1'b1;
          end
        end
        READ: begin
          if (!bus.start_conv) begin
            state   <= IDLE;
            rd_en_r <= 1'b0;
            tap_cnt <= '0;
            busy_r  <= 1'b0;
          end else if (tap_cnt == LAST_TAP) begin
            state     <= DRAIN;
            rd_en_r   <= 1'b0;
            tap_cnt   <= '0;
            drain_cnt <= 1'b0;
          end else begin
            tap_cnt <= tap_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!bus.start_conv) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (drain_cnt) begin
            state             <= DONE;
            complete_r        <= 1'b1;
            {ovf_r, result_r} <= sat_res;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.start_conv) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            state <= REARM;
          end
        end
        REARM: begin
          if (!bus.start_conv) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rd_en_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      prod_p1 <= '0;
      acc_p2  <= '0;
    end else begin
      // p0: buffer read data returns the cycle after rd_en
      vld_p0 <= pipe_clr ? 1'b0 : rd_en_r;
      // p1: full-precision product
      vld_p1 <= pipe_clr ? 1'b0 : vld_p0;
      if (vld_p0)
        prod_p1 <= smp_p0 * cof_p0;
      // p2: accumulate, wide enough that NUM_TAPS products never wrap
      if (start_acc)
        acc_p2 <= '0;
      else if (vld_p1)
        acc_p2 <= acc_p2 + prod_ext;
    end
  end

  assign bus.rd_en         = rd_en_r;
  assign bus.tap_addr      = tap_cnt;
  assign bus.busy          = busy_r;
  assign bus.conv_complete = complete_r;
  assign bus.conv_result   = result_r;
  assign bus.overflow      = ovf_r;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer: directed and randomized tap sets,
// expected results from a plain-arithmetic dot-product model.
module tb_conv_mac_sequencer;

  localparam int NUM_TAPS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 16;
  localparam int COEFF_W  = 16;

  typedef struct {
    logic signed [DATA_W-1:0] res;
    logic                     ovf;
  } exp_t;

  logic clk;
  logic n_rst;

  conv_mac_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COEFF_W(COEFF_W)) bus();

  conv_mac_sequencer #(
    .NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .COEFF_W(COEFF_W), .FRAC_BITS(15)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic signed [DATA_W-1:0]  samp_mem [NUM_TAPS];
  logic signed [COEFF_W-1:0] coef_mem [NUM_TAPS];
  logic signed [DATA_W-1:0]  last_res;
  logic                      last_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer read port model: data appears one cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.sample_data <= samp_mem[bus.tap_addr];
      bus.coeff_data  <= coef_mem[bus.tap_addr];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model();
    longint sum;
    longint sh;
    exp_t   e;
    sum = 0;
    for (int i = 0; i < NUM_TAPS; i++)
      sum += longint'(samp_mem[i]) * longint'(coef_mem[i]);
    sh = sum >>> 15;
    if (sh > 32767) begin
      e.res = 16'sh7FFF; e.ovf = 1'b1;
    end else if (sh < -32768) begin
      e.res = 16'sh8000; e.ovf = 1'b1;
    end else begin
      e.res = 16'(sh); e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (n_rst && bus.conv_complete) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_complete", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("conv_result", longint'(bus.conv_result), longint'(e.res));
        chk("overflow", longint'(bus.overflow), longint'(e.ovf));
      end
    end
  end

  // Called just after a negedge; returns just after a negedge.
  task automatic full_run(input bit hold);
    exp_t e;
    e = ref_model();
    exp_q.push_back(e);
    last_res = e.res;
    last_ovf = e.ovf;
    bus.start_conv = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("rd_en", longint'(bus.rd_en), (c <= 8) ? 1 : 0);
      chk("tap_addr", longint'(bus.tap_addr), (c <= 8) ? c - 1 : 0);
      chk("busy", longint'(bus.busy), 1);
      chk("complete_timing", longint'(bus.conv_complete), (c == 11) ? 1 : 0);
    end
    if (hold) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        chk("rearm_busy", longint'(bus.busy), 1);
        chk("rearm_complete", longint'(bus.conv_complete), 0);
        chk("rearm_rd_en", longint'(bus.rd_en), 0);
      end
    end
    bus.start_conv = 1'b0;
    @(negedge clk);
    chk("idle_busy", longint'(bus.busy), 0);
  endtask

  task automatic fill(input logic signed [DATA_W-1:0] s, input logic signed [COEFF_W-1:0] k);
    for (int i = 0; i < NUM_TAPS; i++) begin
      samp_mem[i] = s;
      coef_mem[i] = k;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, longint'(bus.rd_en), 0);
    chk({tag, "_tap_addr"}, longint'(bus.tap_addr), 0);
    chk({tag, "_busy"}, longint'(bus.busy), 0);
    chk({tag, "_complete"}, longint'(bus.conv_complete), 0);
    chk({tag, "_result"}, longint'(bus.conv_result), 0);
    chk({tag, "_overflow"}, longint'(bus.overflow), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    bus.start_conv  = 1'b0;
    bus.sample_data = '0;
    bus.coeff_data  = '0;
    fill(16'sh0000, 16'sh0000);
    last_res = '0;
    last_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Nominal
    fill(16'sh1000, 16'sh4000);
    full_run(1'b0);

    // Positive saturation then zero coefficients
    fill(16'sh7FFF, 16'sh7FFF);
    full_run(1'b0);
    fill(16'sh7FFF, 16'sh0000);
    full_run(1'b0);

    // Negative saturation and mixed signs
    fill(16'sh8000, 16'sh7FFF);
    full_run(1'b0);
    for (int i = 0; i < NUM_TAPS; i++) begin
      samp_mem[i] = (i % 2 == 0) ? 16'sh1000 : -16'sh1000;
      coef_mem[i] = 16'sh4000;
    end
    full_run(1'b0);

    // Abort in cycle 4: result from the previous run must survive
    fill(16'sh7FFF, 16'sh7FFF);
    bus.start_conv = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("abort_rd_en", longint'(bus.rd_en), 1);
      chk("abort_tap_addr", longint'(bus.tap_addr), c - 1);
    end
    bus.start_conv = 1'b0;
    for (int c = 5; c <= 14; c++) begin
      @(negedge clk);
      chk("abort_busy", longint'(bus.busy), 0);
      chk("abort_rd_en_low", longint'(bus.rd_en), 0);
      chk("abort_no_complete", longint'(bus.conv_complete), 0);
    end
    chk("abort_result_kept", longint'(bus.conv_result), longint'(last_res));
    chk("abort_ovf_kept", longint'(bus.overflow), longint'(last_ovf));
    fill(16'sh1000, 16'sh4000);
    full_run(1'b0);

    // Rearm: level held high, then a one-cycle drop starts a new run
    fill(16'sh8000, 16'sh7FFF);
    full_run(1'b1);
    fill(16'sh1000, 16'sh4000);
    full_run(1'b0);

    // Asynchronous reset in cycle 6
    fill(16'sh7FFF, 16'sh7FFF);
    bus.start_conv = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("prereset_tap_addr", longint'(bus.tap_addr), c - 1);
    end
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    bus.start_conv = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    last_res = '0;
    last_ovf = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_complete", longint'(bus.conv_complete), 0);
    fill(16'sh1000, 16'sh4000);
    full_run(1'b0);

    // Randomized tap sets, alternating full-range and small coefficients
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        samp_mem[i] = 16'($urandom);
        if (r % 2 == 1)
          coef_mem[i] = 16'($urandom);
        else
          coef_mem[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
      end
      full_run(1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
